// File: rtl/h264_intra_nxn_pred.sv
// h264_intra_nxn_pred: NxN luma intra predictor (V/H/DC) with SAD mode decision and residual output.
//   clk, rst_n             clock, asynchronous active-low reset
//   new_slice              synchronous abort back to IDLE
//   src_valid/src          source row in; accepted when src_ready=1
//   top, left              neighbour row/column, sampled with row 0
//   top_av, left_av        neighbour availability, sampled with row 0
//   src_ready              block can accept source rows (IDLE or LOAD)
//   res_ready              downstream can take a residual row
//   res_valid/res/row      signed residual row (src - pred) and its row index
//   mode_valid/mode/sad    one-cycle pulse with chosen mode (0=V,1=H,2=DC) and its SAD
module h264_intra_nxn_pred #(
    parameter int N = 4,
    parameter int BITS = 8,
    localparam int LGN = $clog2(N),
    localparam int SADW = BITS + 2 * LGN,
    localparam int RW = BITS + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_slice,
    input  logic              src_valid,
    input  logic [N*BITS-1:0] src,
    input  logic [N*BITS-1:0] top,
    input  logic [N*BITS-1:0] left,
    input  logic              top_av,
    input  logic              left_av,
    output logic              src_ready,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [N*RW-1:0]   res,
    output logic [LGN-1:0]    row,
    output logic              mode_valid,
    output logic [1:0]        mode,
    output logic [SADW-1:0]   sad
);
    localparam int WW = BITS + LGN + 1;
    typedef enum logic [1:0] {IDLE, LOAD, DECIDE, EMIT} state_t;
    state_t state;
    logic [LGN-1:0] cnt;
    logic [N*BITS-1:0] src_q [N];
    logic [N*BITS-1:0] top_q, left_q, top_c, left_c;
    logic tav_q, lav_q, tav_c, lav_c, idle;
    logic [WW-1:0] st, sl;
    logic [BITS-1:0] dc;
    logic [SADW-1:0] sad_v, sad_h, sad_d, rv, rh, rd, ssel;
    logic [1:0] msel;
    logic [N*RW-1:0] res_c;
    function automatic logic [BITS-1:0] ad(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return a > b ? a - b : b - a;
    endfunction
    // Row 0 is scored against the neighbours on the inputs, later rows against the latched copies.
    assign idle = state == IDLE;
    assign top_c = idle ? top : top_q;
    assign left_c = idle ? left : left_q;
    assign tav_c = idle ? top_av : tav_q;
    assign lav_c = idle ? left_av : lav_q;
    assign src_ready = state == IDLE || state == LOAD;
    always_comb begin
        st = '0;
        sl = '0;
        for (int x = 0; x < N; x++) begin
            st = st + WW'(top_c[x*BITS +: BITS]);
            sl = sl + WW'(left_c[x*BITS +: BITS]);
        end
    end
    assign dc = tav_c && lav_c ? BITS'((st + sl + WW'(N)) >> (LGN + 1)) :
                tav_c ? BITS'((st + WW'(N / 2)) >> LGN) :
                lav_c ? BITS'((sl + WW'(N / 2)) >> LGN) :
                BITS'(1 << (BITS - 1));
    always_comb begin
        rv = '0;
        rh = '0;
        rd = '0;
        for (int x = 0; x < N; x++) begin
            rv = rv + SADW'(ad(src[x*BITS +: BITS], top_c[x*BITS +: BITS]));
            rh = rh + SADW'(ad(src[x*BITS +: BITS], left_c[cnt*BITS +: BITS]));
            rd = rd + SADW'(ad(src[x*BITS +: BITS], dc));
        end
    end
    // Ties go to the lowest mode number, so V and H win on <=.
    assign msel = tav_q && sad_v <= sad_d && (!lav_q || sad_v <= sad_h) ? 2'd0 :
                  lav_q && sad_h <= sad_d ? 2'd1 : 2'd2;
    assign ssel = msel == 2'd0 ? sad_v : msel == 2'd1 ? sad_h : sad_d;
    always_comb begin
        res_c = '0;
        for (int x = 0; x < N; x++)
            res_c[x*RW +: RW] = {1'b0, src_q[cnt][x*BITS +: BITS]} -
                                {1'b0, (mode == 2'd0 ? top_q[x*BITS +: BITS] :
                                        mode == 2'd1 ? left_q[cnt*BITS +: BITS] : dc)};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            for (int i = 0; i < N; i++) src_q[i] <= '0;
            top_q <= '0;
            left_q <= '0;
            tav_q <= 1'b0;
            lav_q <= 1'b0;
            sad_v <= '0;
            sad_h <= '0;
            sad_d <= '0;
            res_valid <= 1'b0;
            res <= '0;
            row <= '0;
            mode_valid <= 1'b0;
            mode <= '0;
            sad <= '0;
        end else if (new_slice) begin
            state <= IDLE;
            cnt <= '0;
            res_valid <= 1'b0;
            mode_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            mode_valid <= 1'b0;
            case (state)
                IDLE: if (src_valid) begin
                    src_q[0] <= src;
                    top_q <= top;
                    left_q <= left;
                    tav_q <= top_av;
                    lav_q <= left_av;
                    sad_v <= rv;
                    sad_h <= rh;
                    sad_d <= rd;
                    cnt <= LGN'(1);
                    state <= LOAD;
                end
                LOAD: if (src_valid) begin
                    src_q[cnt] <= src;
                    sad_v <= sad_v + rv;
                    sad_h <= sad_h + rh;
                    sad_d <= sad_d + rd;
                    cnt <= cnt + LGN'(1);
                    state <= cnt == LGN'(N - 1) ? DECIDE : LOAD;
                end
                DECIDE: begin
                    mode <= msel;
                    sad <= ssel;
                    mode_valid <= 1'b1;
                    state <= EMIT;
                end
                EMIT: if (res_ready) begin
                    res <= res_c;
                    row <= cnt;
                    res_valid <= 1'b1;
                    cnt <= cnt + LGN'(1);
                    state <= cnt == LGN'(N - 1) ? IDLE : EMIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_h264_intra_nxn_pred.sv
// tb_h264_intra_nxn_pred: directed self-checking bench for h264_intra_nxn_pred (N=4, BITS=8).
module tb_h264_intra_nxn_pred;
    logic clk = 1'b0, rst_n = 1'b0, new_slice = 1'b0, src_valid = 1'b0;
    logic [31:0] src = '0, top = '0, left = '0;
    logic top_av = 1'b0, left_av = 1'b0, res_ready = 1'b1;
    logic src_ready, res_valid, mode_valid;
    logic [35:0] res;
    logic [1:0] row, mode;
    logic [11:0] sad;
    int total = 0, bad = 0;
    h264_intra_nxn_pred #(.N(4), .BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .new_slice(new_slice), .src_valid(src_valid), .src(src),
        .top(top), .left(left), .top_av(top_av), .left_av(left_av), .src_ready(src_ready),
        .res_ready(res_ready), .res_valid(res_valid), .res(res), .row(row),
        .mode_valid(mode_valid), .mode(mode), .sad(sad)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic load_rows(input logic [127:0] blk, input logic [31:0] t, input logic [31:0] l,
                             input logic ta, input logic la);
        for (int r = 0; r < 4; r++) begin
            src_valid = 1'b1;
            src = blk[r*32 +: 32];
            top = r == 0 ? t : 32'hFFFFFFFF;
            left = r == 0 ? l : 32'hFFFFFFFF;
            top_av = r == 0 ? ta : ~ta;
            left_av = r == 0 ? la : ~la;
            @(negedge clk);
        end
        src_valid = 1'b0;
        src = '0;
    endtask
    task automatic run_blk(input string nm, input logic [127:0] blk, input logic [31:0] t,
                           input logic [31:0] l, input logic ta, input logic la, input logic [1:0] em,
                           input logic [11:0] es, input logic [8:0] er, input bit stall);
        int nr = 0, cyc = 0;
        load_rows(blk, t, l, ta, la);
        chk({nm, ".rdy_decide"}, src_ready, 0);
        chk({nm, ".mv_early"}, mode_valid, 0);
        @(negedge clk);
        chk({nm, ".mv"}, mode_valid, 1);
        chk({nm, ".mode"}, mode, em);
        chk({nm, ".sad"}, sad, es);
        while (nr < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin
                chk($sformatf("%s.row%0d", nm, nr), row, nr);
                chk($sformatf("%s.res%0d", nm, nr), res, {4{er}});
                nr++;
                chk($sformatf("%s.rdy%0d", nm, nr), src_ready, nr == 4);
                if (stall && nr == 2) begin
                    res_ready = 1'b0;
                    src_valid = 1'b1;
                    src = 32'h12345678;
                    repeat (3) begin
                        @(negedge clk);
                        chk({nm, ".hold_v"}, res_valid, 0);
                        chk({nm, ".hold_row"}, row, 1);
                        chk({nm, ".hold_res"}, res, {4{er}});
                        chk({nm, ".hold_rdy"}, src_ready, 0);
                    end
                    res_ready = 1'b1;
                    src_valid = 1'b0;
                    src = '0;
                end
            end
        end
        chk({nm, ".rows"}, nr, 4);
        @(negedge clk);
        chk({nm, ".v_drop"}, res_valid, 0);
        chk({nm, ".rdy_end"}, src_ready, 1);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst.rdy", src_ready, 1);
        chk("rst.v", res_valid, 0);
        chk("rst.mv", mode_valid, 0);
        chk("rst.res", res, 0);
        chk("rst.row", row, 0);
        chk("rst.mode", mode, 0);
        chk("rst.sad", sad, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_blk("t1", {16{8'h47}}, 32'h36363636, 32'h28282828, 1, 1, 2'd0, 12'd272, 9'h011, 0);
        run_blk("t2", {4{32'h281E140A}}, 32'h281E140A, 32'h00000000, 1, 0, 2'd0, 12'd0, 9'h000, 0);
        run_blk("t3a", {16{8'h80}}, 32'h80808080, 32'h80808080, 0, 0, 2'd2, 12'd0, 9'h000, 0);
        run_blk("t3b", {16{8'h00}}, 32'h80808080, 32'h80808080, 0, 0, 2'd2, 12'd2048, 9'h180, 0);
        run_blk("t4", {16{8'h50}}, 32'h50505050, 32'h50505050, 1, 1, 2'd0, 12'd0, 9'h000, 0);
        run_blk("t5", {16{8'h47}}, 32'h36363636, 32'h28282828, 1, 1, 2'd0, 12'd272, 9'h011, 1);
        run_blk("th", {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010},
                32'h36363636, 32'h40302010, 1, 1, 2'd1, 12'd0, 9'h000, 0);
        src_valid = 1'b1;
        top = 32'h50505050;
        left = 32'h50505050;
        top_av = 1'b1;
        left_av = 1'b1;
        src = 32'h50505050;
        repeat (2) @(negedge clk);
        new_slice = 1'b1;
        @(negedge clk);
        new_slice = 1'b0;
        src_valid = 1'b0;
        chk("t6.rdy", src_ready, 1);
        chk("t6.mv", mode_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t6.mv_none", mode_valid, 0);
        end
        run_blk("t6", {16{8'h47}}, 32'h36363636, 32'h28282828, 1, 1, 2'd0, 12'd272, 9'h011, 0);
        load_rows({16{8'h00}}, 32'h80808080, 32'h80808080, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6r.pre_v", res_valid, 1);
        chk("t6r.pre_sad", sad, 12'd2048);
        #2 rst_n = 1'b0;
        #1;
        chk("t6r.v", res_valid, 0);
        chk("t6r.res", res, 0);
        chk("t6r.mode", mode, 0);
        chk("t6r.sad", sad, 0);
        chk("t6r.rdy", src_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6r.no_out", res_valid, 0);
        end
        run_blk("t6b", {16{8'h50}}, 32'h50505050, 32'h50505050, 1, 1, 2'd0, 12'd0, 9'h000, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
